// File: rtl/tile_color_accum_pkg.sv
// tile_accum_pkg: shared constants and types for the tile colour accumulator.
//   - default active-video geometry and the derived 4x4 tile size
//   - sampling-window size (64 x 32 = 2^11 samples per tile) and centring helper
//   - accumulator width and the capture state enum
package tile_accum_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int TILE_W       = H_ACTIVE_DEF / 4;
  localparam int TILE_H       = V_ACTIVE_DEF / 4;

  localparam int N_TILES      = 16;
  localparam int PIX_W        = 8;

  // Sampling window: fixed size, centred inside each tile.
  localparam int WIN_W        = 64;
  localparam int WIN_H        = 32;
  localparam int WIN_SHIFT    = 11;  // log2(WIN_W * WIN_H)

  // 8-bit samples times 2^11 samples per tile.
  localparam int SUM_W        = PIX_W + WIN_SHIFT;

  // Offset that centres a window of size win inside a tile of size tile.
  function automatic int win_off(input int tile, input int win);
    return (tile - win) / 2;
  endfunction

  localparam int WIN_X0       = win_off(TILE_W, WIN_W);  // 48 at defaults
  localparam int WIN_Y0       = win_off(TILE_H, WIN_H);  // 44 at defaults

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SOF,
    S_ACCUM,
    S_DIV,
    S_DONE
  } state_t;

endpackage

// File: rtl/tile_color_accum_if.sv
// tile_color_accum_if: pixel input stream and tile-average result bundle.
//   i_start, i_valid, i_sof, i_r/i_g/i_b : capture request and pixel stream
//   o_busy, o_done, o_blocks             : status and 16 packed 24-bit averages
// master: the pixel source / result consumer side. slave: the accumulator.
interface tile_color_accum_if;

  logic         i_start;
  logic         i_valid;
  logic         i_sof;
  logic [7:0]   i_r;
  logic [7:0]   i_g;
  logic [7:0]   i_b;
  logic         o_busy;
  logic         o_done;
  logic [383:0] o_blocks;

  modport master (
    output i_start, i_valid, i_sof, i_r, i_g, i_b,
    input  o_busy, o_done, o_blocks
  );

  modport slave (
    input  i_start, i_valid, i_sof, i_r, i_g, i_b,
    output o_busy, o_done, o_blocks
  );

endinterface

// File: rtl/tile_color_accum_decode.sv
// tile_window_decode: combinational map from a pixel position to its tile.
//   x, y     : pixel position inside the active frame
//   tile_idx : row*4 + col of the 4x4 tile containing (x, y)
//   in_win   : high when (x, y) lies inside that tile's centred sampling window
// Tile column/row come from range compares, so no divider is built.
module tile_window_decode
  import tile_accum_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int XW       = $clog2(H_ACTIVE),
  parameter int YW       = $clog2(V_ACTIVE)
) (
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  output logic [3:0]    tile_idx,
  output logic          in_win
);

  localparam int TW = H_ACTIVE / 4;
  localparam int TH = V_ACTIVE / 4;

  localparam logic [XW-1:0] TX1 = XW'(TW);
  localparam logic [XW-1:0] TX2 = XW'(2 * TW);
  localparam logic [XW-1:0] TX3 = XW'(3 * TW);
  localparam logic [YW-1:0] TY1 = YW'(TH);
  localparam logic [YW-1:0] TY2 = YW'(2 * TH);
  localparam logic [YW-1:0] TY3 = YW'(3 * TH);

  localparam logic [XW-1:0] WX0 = XW'(win_off(TW, WIN_W));
  localparam logic [XW-1:0] WX1 = XW'(win_off(TW, WIN_W) + WIN_W);
  localparam logic [YW-1:0] WY0 = YW'(win_off(TH, WIN_H));
  localparam logic [YW-1:0] WY1 = YW'(win_off(TH, WIN_H) + WIN_H);

  logic [1:0]    col;
  logic [1:0]    row;
  logic [XW-1:0] rel_x;
  logic [YW-1:0] rel_y;

  always_comb begin
    col   = 2'd0;
    rel_x = x;
    if (x >= TX3) begin
      col   = 2'd3;
      rel_x = x - TX3;
    end else if (x >= TX2) begin
      col   = 2'd2;
      rel_x = x - TX2;
    end else if (x >= TX1) begin
      col   = 2'd1;
      rel_x = x - TX1;
    end

    row   = 2'd0;
    rel_y = y;
    if (y >= TY3) begin
      row   = 2'd3;
      rel_y = y - TY3;
    end else if (y >= TY2) begin
      row   = 2'd2;
      rel_y = y - TY2;
    end else if (y >= TY1) begin
      row   = 2'd1;
      rel_y = y - TY1;
    end

    tile_idx = {row, col};
    in_win   = (rel_x >= WX0) && (rel_x < WX1) && (rel_y >= WY0) && (rel_y < WY1);
  end

endmodule

// File: rtl/tile_color_accum.sv
// tile_color_accum: captures one frame on request and averages R/G/B over a
// centred 64x32 window in each cell of a 4x4 tile grid.
//   i_clk    : pixel clock
//   i_rst_n  : asynchronous active-low reset
//   bus      : tile_color_accum_if.slave
//              i_start (sampled in S_IDLE), i_valid, i_sof, i_r/i_g/i_b in;
//              o_busy, o_done (one-cycle strobe), o_blocks (tile k at [24k+:24],
//              R[23:16] G[15:8] B[7:0]) out
// Build option: define TILE_ACCUM_ROUND_EN for round-half-up averages;
// otherwise averages truncate. Timing is the same either way.
module tile_color_accum
  import tile_accum_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  tile_color_accum_if.slave bus
);

  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  state_t           state_q, state_d;
  logic [XW-1:0]    x_q;
  logic [YW-1:0]    y_q;
  logic [3:0]       div_cnt_q;
  logic [SUM_W-1:0] sum_r_q [N_TILES];
  logic [SUM_W-1:0] sum_g_q [N_TILES];
  logic [SUM_W-1:0] sum_b_q [N_TILES];
  logic [383:0]     blocks_q;

  logic             sof_take;
  logic             accept;
  logic             last_px;
  logic [XW-1:0]    pos_x;
  logic [YW-1:0]    pos_y;
  logic [3:0]       tile_idx;
  logic             in_win;

  // Sum / 2^11, optionally rounded half-up. 20-bit intermediate; the result
  // never exceeds 255.
  function automatic logic [7:0] tile_avg(input logic [SUM_W-1:0] s);
    logic [SUM_W:0] t;
`ifdef TILE_ACCUM_ROUND_EN
    t = {1'b0, s} + (SUM_W + 1)'(1 << (WIN_SHIFT - 1));
`else
    t = {1'b0, s};
`endif
    return 8'(t >> WIN_SHIFT);
  endfunction

  // A start-of-frame pixel forces position (0,0) both when waiting for a
  // frame and mid-capture (frame restart).
  always_comb begin
    sof_take = bus.i_valid && bus.i_sof &&
               ((state_q == S_WAIT_SOF) || (state_q == S_ACCUM));
    accept   = sof_take || ((state_q == S_ACCUM) && bus.i_valid);
    pos_x    = sof_take ? '0 : x_q;
    pos_y    = sof_take ? '0 : y_q;
    last_px  = accept && (state_q == S_ACCUM) && (pos_x == X_LAST) && (pos_y == Y_LAST);
  end

  tile_window_decode #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .XW       (XW),
    .YW       (YW)
  ) u_decode (
    .x        (pos_x),
    .y        (pos_y),
    .tile_idx (tile_idx),
    .in_win   (in_win)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (bus.i_start)        state_d = S_WAIT_SOF;
      S_WAIT_SOF: if (sof_take)           state_d = S_ACCUM;
      S_ACCUM:    if (last_px)            state_d = S_DIV;
      S_DIV:      if (div_cnt_q == 4'd15) state_d = S_DONE;
      S_DONE:                             state_d = S_IDLE;
      default:                            state_d = S_IDLE;
    endcase
  end

  // Control: state, position and divide counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      div_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        if (pos_x == X_LAST) begin
          x_q <= '0;
          y_q <= (pos_y == Y_LAST) ? '0 : pos_y + YW'(1);
        end else begin
          x_q <= pos_x + XW'(1);
          y_q <= pos_y;
        end
      end
      if (state_q == S_DIV) begin
        div_cnt_q <= div_cnt_q + 4'd1;
      end else if (last_px) begin
        div_cnt_q <= '0;
      end
    end
  end

  // Accumulate: sums clear on a taken sof; the in-window pixel adds on top
  // of the cleared (or held) value in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < N_TILES; k++) begin
        sum_r_q[k] <= '0;
        sum_g_q[k] <= '0;
        sum_b_q[k] <= '0;
      end
    end else if (accept) begin
      for (int k = 0; k < N_TILES; k++) begin
        if (sof_take) begin
          sum_r_q[k] <= '0;
          sum_g_q[k] <= '0;
          sum_b_q[k] <= '0;
        end
        if (in_win && (tile_idx == k[3:0])) begin
          sum_r_q[k] <= (sof_take ? '0 : sum_r_q[k]) + SUM_W'(bus.i_r);
          sum_g_q[k] <= (sof_take ? '0 : sum_g_q[k]) + SUM_W'(bus.i_g);
          sum_b_q[k] <= (sof_take ? '0 : sum_b_q[k]) + SUM_W'(bus.i_b);
        end
      end
    end
  end

  // Divide: one tile per cycle into the packed output
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      blocks_q <= '0;
    end else if (state_q == S_DIV) begin
      blocks_q[int'(div_cnt_q) * 24 +: 24] <= {tile_avg(sum_r_q[div_cnt_q]),
                                               tile_avg(sum_g_q[div_cnt_q]),
                                               tile_avg(sum_b_q[div_cnt_q])};
    end
  end

  assign bus.o_busy   = (state_q != S_IDLE);
  assign bus.o_done   = (state_q == S_DONE);
  assign bus.o_blocks = blocks_q;

endmodule

// File: doc/tile_color_accum.md
# tile_color_accum

Upstream stage of the Klotski tile-colour sorter. It consumes the camera's active-video pixel stream and, on request, captures one full frame. For each cell of a 4x4 tile grid it averages R, G and B over a fixed centred sampling window. It then presents the 16 packed 24-bit averages, plus a one-cycle done strobe, directly to the RGB sort stage's block inputs and start input.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame

Ports:
- i_clk  in  1  pixel-domain clock
- i_rst_n  in  1  reset; one clock, asynchronous, active-low
- i_start  in  1  capture request; sampled only in S_IDLE
- i_valid  in  1  pixel qualifier; i_r/i_g/i_b are meaningful only when high
- i_sof  in  1  start of frame; coincides with the first valid pixel (x=0, y=0)
- i_r, i_g, i_b  in  8 each  pixel colour components
- o_busy  out  1  high in every state except S_IDLE
- o_done  out  1  one-cycle strobe; o_blocks is valid from this cycle
- o_blocks  out  384  tile k at [24k+23:24k]: R [23:16], G [15:8], B [7:0]; tile k = row*4 + col, row-major from the top-left

## Operation
- Tile size: TILE_W = H_ACTIVE/4 = 160, TILE_H = V_ACTIVE/4 = 120.
- Sampling window per tile: 64 x 32 px, at tile-relative x 48..111 and y 44..75. Each tile therefore contributes exactly 2048 = 2^11 samples.
- Position tracking: internal x/y counters advance on each i_valid. x wraps at H_ACTIVE-1 and increments y.
- Pixels arriving after (H_ACTIVE-1, V_ACTIVE-1) and before the next i_sof are ignored.
- Accumulators: 16 x 3 sums, 19 bits each (8 + 11). A sum cannot overflow.
- States:
  - S_IDLE: if i_start, go to S_WAIT_SOF.
  - S_WAIT_SOF: when i_valid && i_sof:
    - clear all sums;
    - treat this pixel as (0,0) and accumulate it if it lies in a window;
    - go to S_ACCUM.
  - S_ACCUM: accumulate in-window valid pixels. When the pixel at (H_ACTIVE-1, V_ACTIVE-1) is accepted, go to S_DIV with tile counter = 0.
  - S_DIV: 16 cycles. Each cycle writes the average of tile[counter], all three channels, into o_blocks, then increments the counter. After tile 15, go to S_DONE.
  - S_DONE: o_done = 1 for one cycle, then S_IDLE.
- Averaging: avg = (sum + 1024) >> 11, computed at 20-bit width. The maximum result is 255, so no saturation is needed. The rounding term depends on the configuration macro.
- o_blocks holds its value from one o_done until the S_DIV of the next capture. Partial overwrite during S_DIV is permitted.

## Timing
- Reset values: o_busy = 0, o_done = 0, o_blocks = 0. All sums, counters and the state (S_IDLE) are cleared.
- Latency: the last pixel is accepted at cycle N. S_DIV runs over cycles N+1 .. N+16. o_done is high at N+17.
- i_start while busy: ignored, with no queuing.
- i_sof while in S_ACCUM: the frame restarts. Sums clear, the current pixel becomes (0,0) and is accumulated if in a window; the state stays in S_ACCUM.
- i_sof in S_DIV or S_DONE: ignored.
- i_valid low: counters and sums hold.
- Asynchronous reset at any point aborts the capture and returns the block to reset values.

## Configuration
- Macro TILE_ACCUM_ROUND_EN:
  - Defined: round-half-up, avg = (sum + 1024) >> 11.
  - Undefined: truncate, avg = sum >> 11.
- The state machine and latency are identical in both cases.

## Structure
- Package tile_accum_pkg:
  - H_ACTIVE/V_ACTIVE defaults;
  - TILE_W, TILE_H;
  - window offset and size localparams;
  - SUM_W = 19;
  - the state enum (S_IDLE, S_WAIT_SOF, S_ACCUM, S_DIV, S_DONE).
- Sub-module tile_window_decode: purely combinational. Maps (x, y) to a 4-bit tile index plus an in-window flag. This keeps the accumulator loop a single indexed add.

## Test plan
- Uniform frame with every pixel R=0x40, G=0x80, B=0xC0 -> o_done at N+17; all 16 tiles read 0x4080C0; o_busy drops the cycle after o_done.
- Each tile filled with a distinct colour (tile k = {k*16, 255-k*16, k}) -> o_blocks[24k+:24] matches per tile, confirming row-major ordering.
- In-window pixels 0x000000, all other pixels 0xFFFFFF -> all tiles read 0x000000, confirming window bounds.
- One tile window split into half R=10 and half R=11 -> R = 11 with TILE_ACCUM_ROUND_EN defined, 10 without.
- i_sof reasserted at (300, 200) followed by a full clean uniform frame -> output reflects only the second frame; i_start pulses during S_ACCUM have no effect.
- i_rst_n pulled low mid-S_ACCUM then released, followed by i_start and a frame -> o_blocks = 0 immediately after reset; a correct capture follows.
